// File: rtl/difftest_snapshot_csr_trigger_if.sv
// Bus bundle between the difftest CSR snapshot trigger and its driver/consumer.
// Optional CSR write port exists only when DIFFTEST_SNAPSHOT_CSR_WRITE_EN is defined.
interface difftest_snapshot_csr_trigger_if #(
    parameter int COMMIT_W = 3,
    parameter int CNT_W    = 32
);
    logic [7:0]          io_hartid;
    logic                io_cycle_inhibit;
    logic                io_instret_inhibit;
    logic [COMMIT_W-1:0] io_commit_cnt;
    logic                io_snap_req;
`ifdef DIFFTEST_SNAPSHOT_CSR_WRITE_EN
    logic                io_csr_wen;
    logic                io_csr_sel;
    logic [63:0]         io_csr_wdata;
`endif
    logic                enable;
    logic [63:0]         io_minstret;
    logic [63:0]         io_mcycle;
    logic [7:0]          io_coreid;
    logic [CNT_W-1:0]    io_snap_cnt;
    logic [CNT_W-1:0]    io_drop_cnt;

    modport master (
        output io_hartid, io_cycle_inhibit, io_instret_inhibit, io_commit_cnt, io_snap_req,
`ifdef DIFFTEST_SNAPSHOT_CSR_WRITE_EN
        output io_csr_wen, io_csr_sel, io_csr_wdata,
`endif
        input  enable, io_minstret, io_mcycle, io_coreid, io_snap_cnt, io_drop_cnt
    );

    modport slave (
        input  io_hartid, io_cycle_inhibit, io_instret_inhibit, io_commit_cnt, io_snap_req,
`ifdef DIFFTEST_SNAPSHOT_CSR_WRITE_EN
        input  io_csr_wen, io_csr_sel, io_csr_wdata,
`endif
        output enable, io_minstret, io_mcycle, io_coreid, io_snap_cnt, io_drop_cnt
    );
endinterface

// File: rtl/difftest_snapshot_csr_trigger.sv
// Shadow mcycle/minstret counters plus the trigger FSM that emits rate-limited snapshot pulses.
// Define DIFFTEST_SNAPSHOT_CSR_WRITE_EN to add a CSR write port that presets either counter.
module difftest_snapshot_csr_trigger #(
    parameter int COMMIT_W = 3,
    parameter int INTERVAL = 1000,
    parameter int HOLDOFF  = 16,
    parameter int CNT_W    = 32
) (
    input  logic                            clock,
    input  logic                            reset_n,
    difftest_snapshot_csr_trigger_if.slave  snap
);
    localparam int HOLD_INIT = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;
    localparam int HOLD_W    = (HOLD_INIT > 0) ? $clog2(HOLD_INIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_e;

    state_e              state_q, state_d;
    logic [63:0]         mcycle_q, mcycle_d;
    logic [63:0]         minstret_q, minstret_d;
    logic [31:0]         since_q, since_d, since_sum;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                pending_q, pending_d;
    logic [63:0]         cap_mcycle_q, cap_mcycle_d;
    logic [63:0]         cap_minstret_q, cap_minstret_d;
    logic [7:0]          cap_coreid_q, cap_coreid_d;
    logic [CNT_W-1:0]    snap_cnt_q, snap_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [COMMIT_W-1:0] commit;
    logic                auto_trig, trig, capture, drop;

    assign commit = snap.io_commit_cnt;

    // Counter next values; a CSR write overrides increment and inhibit for that cycle.
    always_comb begin
        mcycle_d   = snap.io_cycle_inhibit   ? mcycle_q   : mcycle_q + 64'd1;
        minstret_d = snap.io_instret_inhibit ? minstret_q : minstret_q + 64'(commit);
        since_sum  = snap.io_instret_inhibit ? since_q    : since_q + 32'(commit);
`ifdef DIFFTEST_SNAPSHOT_CSR_WRITE_EN
        if (snap.io_csr_wen) begin
            if (snap.io_csr_sel) begin
                minstret_d = snap.io_csr_wdata;
            end else begin
                mcycle_d = snap.io_csr_wdata;
            end
        end
`endif
        auto_trig = (INTERVAL != 0) && (since_sum >= 32'(INTERVAL));
        since_d   = auto_trig ? 32'd0 : since_sum;
        trig      = auto_trig | snap.io_snap_req;
    end

    // With HOLDOFF == 0 a trigger seen during FIRE re-captures immediately (back-to-back pulses).
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        capture    = 1'b0;
        drop       = 1'b0;
        snap_cnt_d = snap_cnt_q;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    capture = 1'b1;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                if (snap_cnt_q != '1) snap_cnt_d = snap_cnt_q + 1'b1;
                if (HOLDOFF == 0) begin
                    if (trig) begin
                        capture = 1'b1;
                        state_d = FIRE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d  = HOLD_W'(HOLD_INIT);
                    state_d = HOLD;
                    if (trig) begin
                        if (pending_q) drop = 1'b1;
                        else           pending_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (trig) begin
                    if (pending_q) drop = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (hold_q == '0) begin
                    if (pending_q || trig) begin
                        capture   = 1'b1;
                        pending_d = 1'b0;
                        state_d   = FIRE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    assign cap_mcycle_d   = capture ? mcycle_d       : cap_mcycle_q;
    assign cap_minstret_d = capture ? minstret_d     : cap_minstret_q;
    assign cap_coreid_d   = capture ? snap.io_hartid : cap_coreid_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            since_q        <= '0;
            hold_q         <= '0;
            pending_q      <= 1'b0;
            cap_mcycle_q   <= '0;
            cap_minstret_q <= '0;
            cap_coreid_q   <= '0;
            snap_cnt_q     <= '0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            since_q        <= since_d;
            hold_q         <= hold_d;
            pending_q      <= pending_d;
            cap_mcycle_q   <= cap_mcycle_d;
            cap_minstret_q <= cap_minstret_d;
            cap_coreid_q   <= cap_coreid_d;
            snap_cnt_q     <= snap_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign snap.enable      = (state_q == FIRE);
    assign snap.io_minstret = cap_minstret_q;
    assign snap.io_mcycle   = cap_mcycle_q;
    assign snap.io_coreid   = cap_coreid_q;
    assign snap.io_snap_cnt = snap_cnt_q;
    assign snap.io_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_difftest_snapshot_csr_trigger.sv
// Scoreboard bench for difftest_snapshot_csr_trigger with three parameterisations:
// A = (INTERVAL 1000, HOLDOFF 16), B = (INTERVAL 10, HOLDOFF 0), C = (INTERVAL 10, HOLDOFF 4).
module tb_difftest_snapshot_csr_trigger;
    logic clock;
    logic reset_n;

    typedef struct packed {
        logic [63:0] minstret;
        logic [63:0] mcycle;
        logic [7:0]  coreid;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];
    exp_t eA, eB, eC;
    int   compared   = 0;
    int   mismatched = 0;

    difftest_snapshot_csr_trigger_if #(.COMMIT_W(3), .CNT_W(32)) ifA ();
    difftest_snapshot_csr_trigger_if #(.COMMIT_W(3), .CNT_W(32)) ifB ();
    difftest_snapshot_csr_trigger_if #(.COMMIT_W(3), .CNT_W(32)) ifC ();

    difftest_snapshot_csr_trigger #(.COMMIT_W(3), .INTERVAL(1000), .HOLDOFF(16), .CNT_W(32)) dutA (
        .clock(clock), .reset_n(reset_n), .snap(ifA));
    difftest_snapshot_csr_trigger #(.COMMIT_W(3), .INTERVAL(10), .HOLDOFF(0), .CNT_W(32)) dutB (
        .clock(clock), .reset_n(reset_n), .snap(ifB));
    difftest_snapshot_csr_trigger #(.COMMIT_W(3), .INTERVAL(10), .HOLDOFF(4), .CNT_W(32)) dutC (
        .clock(clock), .reset_n(reset_n), .snap(ifC));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [63:0] minstret, input logic [63:0] mcycle,
                                input logic [7:0] coreid);
        exp_t e;
        e.minstret = minstret;
        e.mcycle   = mcycle;
        e.coreid   = coreid;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int dut, input logic [2:0] commit, input logic req,
                                 input logic [7:0] hart, input logic cinh, input logic iinh);
        case (dut)
            0: begin
                ifA.io_commit_cnt = commit; ifA.io_snap_req = req; ifA.io_hartid = hart;
                ifA.io_cycle_inhibit = cinh; ifA.io_instret_inhibit = iinh;
            end
            1: begin
                ifB.io_commit_cnt = commit; ifB.io_snap_req = req; ifB.io_hartid = hart;
                ifB.io_cycle_inhibit = cinh; ifB.io_instret_inhibit = iinh;
            end
            default: begin
                ifC.io_commit_cnt = commit; ifC.io_snap_req = req; ifC.io_hartid = hart;
                ifC.io_cycle_inhibit = cinh; ifC.io_instret_inhibit = iinh;
            end
        endcase
    endtask

    task automatic zeroInputs;
        for (int d = 0; d < 3; d++) applyStimulus(d, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef DIFFTEST_SNAPSHOT_CSR_WRITE_EN
        ifA.io_csr_wen = 1'b0; ifA.io_csr_sel = 1'b0; ifA.io_csr_wdata = '0;
        ifB.io_csr_wen = 1'b0; ifB.io_csr_sel = 1'b0; ifB.io_csr_wdata = '0;
        ifC.io_csr_wen = 1'b0; ifC.io_csr_sel = 1'b0; ifC.io_csr_wdata = '0;
`endif
    endtask

    // Releases reset on a falling edge; "cycle 0" is the span up to the next rising edge.
    task automatic doReset;
        reset_n = 1'b0;
        zeroInputs();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic nextCycle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (ifA.enable) begin
            if (qA.size() == 0) begin
                compared++; mismatched++;
                $display("[TB] FAIL A unexpected pulse: got enable=1, expected no pulse");
            end else begin
                eA = qA.pop_front();
                checkOutput("A minstret", ifA.io_minstret, eA.minstret);
                checkOutput("A mcycle", ifA.io_mcycle, eA.mcycle);
                checkOutput("A coreid", 64'(ifA.io_coreid), 64'(eA.coreid));
            end
        end
    end

    always @(negedge clock) begin
        if (ifB.enable) begin
            if (qB.size() == 0) begin
                compared++; mismatched++;
                $display("[TB] FAIL B unexpected pulse: got enable=1, expected no pulse");
            end else begin
                eB = qB.pop_front();
                checkOutput("B minstret", ifB.io_minstret, eB.minstret);
                checkOutput("B mcycle", ifB.io_mcycle, eB.mcycle);
                checkOutput("B coreid", 64'(ifB.io_coreid), 64'(eB.coreid));
            end
        end
    end

    always @(negedge clock) begin
        if (ifC.enable) begin
            if (qC.size() == 0) begin
                compared++; mismatched++;
                $display("[TB] FAIL C unexpected pulse: got enable=1, expected no pulse");
            end else begin
                eC = qC.pop_front();
                checkOutput("C minstret", ifC.io_minstret, eC.minstret);
                checkOutput("C mcycle", ifC.io_mcycle, eC.mcycle);
                checkOutput("C coreid", 64'(ifC.io_coreid), 64'(eC.coreid));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        zeroInputs();
        #12;
        checkOutput("reset A enable", 64'(ifA.enable), 64'd0);
        checkOutput("reset A mcycle", ifA.io_mcycle, 64'd0);
        checkOutput("reset B minstret", ifB.io_minstret, 64'd0);
        checkOutput("reset C snap_cnt", 64'(ifC.io_snap_cnt), 64'd0);
        checkOutput("reset C drop_cnt", 64'(ifC.io_drop_cnt), 64'd0);

        // A: one instruction per cycle, first automatic snapshot at 1000 retired.
        doReset();
        applyStimulus(0, 3'd1, 1'b0, 8'h5A, 1'b0, 1'b0);
        qA.push_back(mk(64'd1000, 64'd1000, 8'h5A));
        nextCycle(1005);
        applyStimulus(0, 3'd0, 1'b0, 8'h5A, 1'b0, 1'b0);
        checkOutput("A snap_cnt", 64'(ifA.io_snap_cnt), 64'd1);
        checkOutput("A drop_cnt", 64'(ifA.io_drop_cnt), 64'd0);

        // B: 7 per cycle against INTERVAL 10 -> pulse every other cycle, residual discarded.
        doReset();
        applyStimulus(1, 3'd7, 1'b0, 8'h01, 1'b0, 1'b0);
        qB.push_back(mk(64'd14, 64'd2, 8'h01));
        qB.push_back(mk(64'd28, 64'd4, 8'h01));
        qB.push_back(mk(64'd42, 64'd6, 8'h01));
        nextCycle(6);
        applyStimulus(1, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0);
        nextCycle(4);
        checkOutput("B snap_cnt", 64'(ifB.io_snap_cnt), 64'd3);
        checkOutput("B drop_cnt", 64'(ifB.io_drop_cnt), 64'd0);

        // C: automatic trigger and request in the same cycle give a single snapshot.
        doReset();
        applyStimulus(2, 3'd7, 1'b0, 8'h33, 1'b0, 1'b0);
        nextCycle(1);
        applyStimulus(2, 3'd7, 1'b1, 8'h33, 1'b0, 1'b0);
        qC.push_back(mk(64'd14, 64'd2, 8'h33));
        nextCycle(1);
        applyStimulus(2, 3'd0, 1'b0, 8'h33, 1'b0, 1'b0);
        nextCycle(10);
        checkOutput("C coinc snap_cnt", 64'(ifC.io_snap_cnt), 64'd1);
        checkOutput("C coinc drop_cnt", 64'(ifC.io_drop_cnt), 64'd0);

        // C: request held three cycles -> pulse, one merged pending pulse after holdoff, one drop.
        doReset();
        applyStimulus(2, 3'd0, 1'b1, 8'h11, 1'b0, 1'b0);
        qC.push_back(mk(64'd0, 64'd1, 8'h11));
        nextCycle(1);
        applyStimulus(2, 3'd0, 1'b1, 8'h22, 1'b0, 1'b0);
        nextCycle(2);
        applyStimulus(2, 3'd0, 1'b0, 8'h22, 1'b0, 1'b0);
        qC.push_back(mk(64'd0, 64'd6, 8'h22));
        nextCycle(10);
        checkOutput("C burst snap_cnt", 64'(ifC.io_snap_cnt), 64'd2);
        checkOutput("C burst drop_cnt", 64'(ifC.io_drop_cnt), 64'd1);

        // C: a request landing exactly on the last holdoff cycle fires directly.
        doReset();
        applyStimulus(2, 3'd0, 1'b1, 8'h44, 1'b0, 1'b0);
        qC.push_back(mk(64'd0, 64'd1, 8'h44));
        nextCycle(1);
        applyStimulus(2, 3'd0, 1'b0, 8'h44, 1'b0, 1'b0);
        nextCycle(4);
        applyStimulus(2, 3'd0, 1'b1, 8'h45, 1'b0, 1'b0);
        qC.push_back(mk(64'd0, 64'd6, 8'h45));
        nextCycle(1);
        applyStimulus(2, 3'd0, 1'b0, 8'h45, 1'b0, 1'b0);
        nextCycle(8);
        checkOutput("C edge snap_cnt", 64'(ifC.io_snap_cnt), 64'd2);
        checkOutput("C edge drop_cnt", 64'(ifC.io_drop_cnt), 64'd0);

        // C: both inhibits high for 20 cycles; commits during that window must not count.
        doReset();
        applyStimulus(2, 3'd0, 1'b1, 8'h55, 1'b0, 1'b0);
        qC.push_back(mk(64'd0, 64'd1, 8'h55));
        nextCycle(1);
        applyStimulus(2, 3'd0, 1'b0, 8'h55, 1'b0, 1'b0);
        nextCycle(9);
        applyStimulus(2, 3'd3, 1'b0, 8'h55, 1'b1, 1'b1);
        nextCycle(20);
        applyStimulus(2, 3'd0, 1'b0, 8'h55, 1'b0, 1'b0);
        nextCycle(10);
        applyStimulus(2, 3'd0, 1'b1, 8'h55, 1'b0, 1'b0);
        qC.push_back(mk(64'd0, 64'd21, 8'h55));
        nextCycle(1);
        applyStimulus(2, 3'd0, 1'b0, 8'h55, 1'b0, 1'b0);
        nextCycle(8);
        checkOutput("C inhibit snap_cnt", 64'(ifC.io_snap_cnt), 64'd2);

`ifdef DIFFTEST_SNAPSHOT_CSR_WRITE_EN
        // C: preset minstret near the top, then wrap; later a same-cycle mcycle write is captured.
        doReset();
        ifC.io_csr_wen = 1'b1; ifC.io_csr_sel = 1'b1; ifC.io_csr_wdata = 64'hFFFF_FFFF_FFFF_FFFD;
        nextCycle(1);
        ifC.io_csr_wen = 1'b0;
        applyStimulus(2, 3'd5, 1'b1, 8'h77, 1'b0, 1'b0);
        qC.push_back(mk(64'd2, 64'd2, 8'h77));
        nextCycle(1);
        applyStimulus(2, 3'd0, 1'b0, 8'h77, 1'b0, 1'b0);
        nextCycle(6);
        ifC.io_csr_wen = 1'b1; ifC.io_csr_sel = 1'b0; ifC.io_csr_wdata = 64'h1234;
        applyStimulus(2, 3'd0, 1'b1, 8'h77, 1'b0, 1'b0);
        qC.push_back(mk(64'd2, 64'h1234, 8'h77));
        nextCycle(1);
        ifC.io_csr_wen = 1'b0;
        applyStimulus(2, 3'd0, 1'b0, 8'h77, 1'b0, 1'b0);
        nextCycle(8);
        checkOutput("C csr snap_cnt", 64'(ifC.io_snap_cnt), 64'd2);
`endif

        // C: reset asserted mid-pulse drops enable without waiting for a clock edge.
        doReset();
        applyStimulus(2, 3'd0, 1'b1, 8'h66, 1'b0, 1'b0);
        nextCycle(1);
        checkOutput("C pre-reset enable", 64'(ifC.enable), 64'd1);
        checkOutput("C pre-reset mcycle", ifC.io_mcycle, 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("C async enable", 64'(ifC.enable), 64'd0);
        checkOutput("C async mcycle", ifC.io_mcycle, 64'd0);
        checkOutput("C async coreid", 64'(ifC.io_coreid), 64'd0);
        checkOutput("C async snap_cnt", 64'(ifC.io_snap_cnt), 64'd0);
        zeroInputs();
        @(negedge clock);
        reset_n = 1'b1;
        nextCycle(20);
        checkOutput("C post-reset snap_cnt", 64'(ifC.io_snap_cnt), 64'd0);

        checkOutput("A pending expectations", 64'(qA.size()), 64'd0);
        checkOutput("B pending expectations", 64'(qB.size()), 64'd0);
        checkOutput("C pending expectations", 64'(qC.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
